demux_9: RTL and testbench
==========================

// Module: demux_9
// PURPOSE
//  Write-side counterpart of the 9-way read mux: routes one 32-bit word to one of 9 destinations chosen by a 4-bit flag.
//  Each destination has a one-entry holding buffer with valid/ack.
//  The source side uses a valid/ready handshake, so a busy destination back-pressures only writes aimed at it.
//  Sits between the datapath result bus and the 9 sink registers/units.
// PARAMETERS
//  WIDTH    32  data width of in/out words
//  N_OUT    9   number of destinations (flag codes 0..N_OUT-1 valid)
//  SEL_W    4   flag width
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         synchronous reset, active low
//  in_data     in   WIDTH     word to route
//  flag        in   SEL_W     destination index (0 -> out_1 ... 8 -> out_9)
//  in_valid    in   1         source presents in_data/flag
//  in_ready    out  1         transfer occurs on in_valid & in_ready
//  out_data    out  N_OUT*WIDTH  packed slot data, slot k at [k*WIDTH +: WIDTH]
//  out_valid   out  N_OUT     slot k holds an unconsumed word
//  out_ack     in   N_OUT     sink k consumes slot k when out_valid[k] & out_ack[k]
//  err_flag    out  1         1-cycle pulse: accepted word had flag >= N_OUT (dropped)
//  drop_cnt    out  8         saturating count of dropped words
// BEHAVIOUR
//  Reset (clk edge with rst_n=0): out_valid=0, out_data=0, err_flag=0, drop_cnt=0. rst_n overrides all same-cycle events.
//  Mid-operation reset discards buffered words with no ack required.
//  in_ready (combinational):
//   - 1 if flag >= N_OUT;
//   - else ~out_valid[flag] | out_ack[flag] (pass-through on same-cycle consume).
//   - in_ready depends only on flag/state/out_ack, never on in_valid.
//  Accept, valid flag k: slot k loads in_data next edge, out_valid[k]=1.
//   - Latency: 1 cycle from accept to out_valid.
//  Consume: out_valid[k] & out_ack[k] & no same-cycle accept to k -> out_valid[k]=0; out_data[k] holds its last value.
//  Simultaneous consume+accept on slot k: new word loads, out_valid[k] stays 1 (zero bubbles, full throughput).
//  out_ack[k] while out_valid[k]=0: ignored.
//  Accept with flag >= N_OUT (9..15): no slot changes; err_flag=1 the next cycle; drop_cnt += 1, saturating at 255.
//  Slots are independent: different slots may be acked in the same cycle; one accept per cycle max.
//  Per-slot state machine: EMPTY -(accept)-> FULL; FULL -(ack, no accept)-> EMPTY; FULL -(ack+accept)-> FULL (reload).
//   - FULL with accept and no ack is impossible (in_ready=0).
//  flag/in_data may change freely while in_valid=0; the source must hold them stable while in_valid=1 & in_ready=0.
// STRUCTURE
//  Shared package/include (cpu_defs): MUX_N_OUT=9, DATA_W=32, SEL_W=4, DROP_CNT_W=8; reused by mux_9 and demux_9.
//  Sub-module demux_slot (WIDTH): one-entry buffer with
//   - inputs: load, d, ack
//   - outputs: q, valid, can_load = ~valid | ack
//  The top instantiates N_OUT slots via a generate loop. Top holds flag decode, in_ready select, and the err/drop logic.
//  No other state.
// TESTING
//  1 Reset: rst_n=0 two cycles with in_valid=1, flag=2 -> out_valid=0, drop_cnt=0, no slot loads.
//  2 Route: send 0xA5A5_0001 flag=0, then 0xDEAD_BEEF flag=8, acks low.
//    -> out_valid=9'h101; slot0=0xA5A50001; slot8=0xDEADBEEF; each 1 cycle after accept.
//  3 Back-pressure: slot3 full, in_valid=1 flag=3 ack=0 -> in_ready=0 for 5 cycles, slot3 data unchanged.
//    Then flag=4 -> in_ready=1, and slot4 loads.
//  4 Pass-through: slot3 full, flag=3 data=0x1234 with out_ack[3]=1 same cycle.
//    -> in_ready=1; next cycle out_valid[3]=1, slot3=0x1234.
//  5 Bad flag: flags 9 and 15 accepted back-to-back -> in_ready=1, err_flag high 2 cycles, drop_cnt=2, out_valid unchanged.
//    Then 300 bad writes -> drop_cnt=255.
//  6 Stress: random flag 0..15, random in_valid/out_ack, 10k cycles vs a scoreboard model.
//    -> no lost or duplicated words, per-slot ordering kept, and in_ready matches the rule every cycle.

Source files
------------

// File: rtl/demux_9_pkg.sv
// Shared constants and types for the 9-way write demux and its slots.
package demux_9_pkg;

  localparam int MUX_N_OUT  = 9;   // number of destinations
  localparam int DATA_W     = 32;  // routed word width
  localparam int MUX_SEL_W  = 4;   // destination flag width
  localparam int DROP_CNT_W = 8;   // saturating drop counter width

  // One-entry holding buffer state.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_9_if.sv
// Source/sink bus of the write demux: a valid/ready source port plus
// per-destination valid/ack sink ports and the drop diagnostics.
interface demux_9_if
  import demux_9_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N_OUT = MUX_N_OUT,
  parameter int SEL_W = MUX_SEL_W
) ();

  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       flag;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ack;
  logic                   err_flag;
  logic [DROP_CNT_W-1:0]  drop_cnt;

  // Environment side: drives words in and acks out.
  modport master (
    output in_data, flag, in_valid, out_ack,
    input  in_ready, out_data, out_valid, err_flag, drop_cnt
  );

  // Demux side.
  modport slave (
    input  in_data, flag, in_valid, out_ack,
    output in_ready, out_data, out_valid, err_flag, drop_cnt
  );

endinterface

// File: rtl/demux_9_slot.sv
// One-entry holding buffer for a single destination. A word loaded while
// the current one is being acked replaces it without a bubble.
module demux_slot
  import demux_9_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             can_load
);

  slot_state_e      state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;

  // State and data registers; reset empties the slot and clears the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= SLOT_EMPTY;
      q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
    end
  end

  // Next state: load fills (or refills), ack without load empties.
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    case (state_reg)
      SLOT_EMPTY: begin
        if (load) begin
          state_next = SLOT_FULL;
          q_next     = d;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          q_next = d;
        end else if (ack) begin
          state_next = SLOT_EMPTY;
        end
      end
      default: state_next = SLOT_EMPTY;
    endcase
  end

  assign q        = q_reg;
  assign valid    = (state_reg == SLOT_FULL);
  assign can_load = (state_reg == SLOT_EMPTY) | ack;

endmodule

// File: rtl/demux_9.sv
// Routes one word per cycle to one of N_OUT one-entry destination buffers
// selected by flag. Only the addressed slot can stall the source; words
// with an out-of-range flag are accepted, dropped and counted.
module demux_9
  import demux_9_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N_OUT = MUX_N_OUT,
  parameter int SEL_W = MUX_SEL_W
) (
  input  logic      clk,
  input  logic      rst_n,
  demux_9_if.slave  bus
);

  localparam logic [SEL_W-1:0] N_OUT_SEL = SEL_W'(N_OUT);

  logic [N_OUT-1:0]       slot_hit;
  logic [N_OUT-1:0]       slot_load;
  logic [N_OUT-1:0]       slot_can_load;
  logic [N_OUT-1:0]       slot_valid;
  logic [WIDTH-1:0]       slot_q [N_OUT];
  logic [N_OUT*WIDTH-1:0] out_data_pack;

  logic                   flag_bad;
  logic                   drop;
  logic                   err_flag_reg;
  logic [DROP_CNT_W-1:0]  drop_cnt_reg, drop_cnt_next;

  assign flag_bad = (bus.flag >= N_OUT_SEL);

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_slot
      assign slot_hit[gi]  = (bus.flag == SEL_W'(gi));
      assign slot_load[gi] = bus.in_valid & slot_hit[gi] & slot_can_load[gi];

      demux_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (slot_load[gi]),
        .d        (bus.in_data),
        .ack      (bus.out_ack[gi]),
        .q        (slot_q[gi]),
        .valid    (slot_valid[gi]),
        .can_load (slot_can_load[gi])
      );
    end
  endgenerate

  // Pack slot contents onto the flat output bus, slot k at [k*WIDTH +: WIDTH].
  always_comb begin
    out_data_pack = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_data_pack[k*WIDTH +: WIDTH] = slot_q[k];
    end
  end

  // Ready never looks at in_valid, so sources may probe before asserting.
  assign bus.in_ready  = flag_bad | (|(slot_hit & slot_can_load));
  assign bus.out_data  = out_data_pack;
  assign bus.out_valid = slot_valid;

  // An accepted out-of-range word is dropped.
  assign drop = bus.in_valid & flag_bad;

  // Saturating drop counter increment.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (drop && (drop_cnt_reg != '1)) begin
      drop_cnt_next = drop_cnt_reg + 1'b1;
    end
  end

  // Drop diagnostics: one-cycle error pulse and running count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_flag_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      err_flag_reg <= drop;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign bus.err_flag = err_flag_reg;
  assign bus.drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_demux_9.sv
// Self-checking bench for demux_9: directed scenarios followed by a
// randomized run. Each slot is modelled as a FIFO of words awaiting
// consumption; a monitor compares the DUT against it every cycle.
module tb_demux_9;
  import demux_9_pkg::*;

  localparam int N = MUX_N_OUT;
  localparam int W = DATA_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  demux_9_if bus ();

  demux_9 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words accepted but not yet consumed, per destination.
  logic [W-1:0] q [N][$];
  logic [W-1:0] last_data [N];
  logic         exp_err  = 1'b0;
  int           exp_drop = 0;
  logic         blocked  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, then update the model
  // with what the next rising edge will do.
  task automatic cycle(input logic r, input logic v, input logic [3:0] f,
                       input logic [W-1:0] d, input logic [N-1:0] ack);
    int  fi;
    logic rdy;
    @(negedge clk);
    rst_n        = r;
    bus.in_valid = v;
    bus.flag     = f;
    bus.in_data  = d;
    bus.out_ack  = ack;
    #3;
    fi = int'(f);
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        q[k].delete();
        last_data[k] = '0;
      end
      exp_err  = 1'b0;
      exp_drop = 0;
      blocked  = 1'b0;
    end else begin
      // The monitor has already retired any word acked this cycle, so an
      // empty queue means the destination can take a word now.
      rdy     = (fi >= N) ? 1'b1 : (q[fi].size() == 0);
      blocked = v && !rdy;
      exp_err = v && rdy && (fi >= N);
      if (exp_err && exp_drop < 255) exp_drop++;
      if (v && rdy && fi < N) begin
        q[fi].push_back(d);
        last_data[fi] = d;
      end
    end
  endtask

  // Monitor: compares handshake, diagnostics and every slot each cycle,
  // retiring a word whenever its sink acks it.
  int   mf;
  logic mon_rdy;
  logic [W-1:0] mon_exp;
  always @(negedge clk) begin
    #2;
    mf = int'(bus.flag);
    if (mf >= N) mon_rdy = 1'b1;
    else         mon_rdy = (q[mf].size() == 0) || bus.out_ack[mf];
    check("in_ready", 32'(bus.in_ready), 32'(mon_rdy));
    check("err_flag", 32'(bus.err_flag), 32'(exp_err));
    check("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
    for (int k = 0; k < N; k++) begin
      check($sformatf("out_valid[%0d]", k), 32'(bus.out_valid[k]), 32'(q[k].size() != 0));
      mon_exp = (q[k].size() != 0) ? q[k][0] : last_data[k];
      check($sformatf("out_data[%0d]", k), bus.out_data[k*W +: W], mon_exp);
      if (rst_n && q[k].size() != 0 && bus.out_ack[k]) begin
        $display("[TB] slot %0d consumed %h", k, q[k][0]);
        void'(q[k].pop_front());
      end
    end
  end

  logic         sv;
  logic [3:0]   sf;
  logic [W-1:0] sd;

  initial begin
    bus.in_valid = 1'b1;
    bus.flag     = 4'd2;
    bus.in_data  = 32'h2222_2222;
    bus.out_ack  = '0;
    for (int k = 0; k < N; k++) last_data[k] = '0;

    // Reset held two cycles with a live write to slot 2.
    cycle(1'b0, 1'b1, 4'd2, 32'h2222_2222, '0);
    cycle(1'b0, 1'b1, 4'd2, 32'h2222_2222, '0);
    check("reset out_valid", 32'(bus.out_valid), 32'h0);
    check("reset drop_cnt",  32'(bus.drop_cnt),  32'h0);

    // Routing to first and last slot, one-cycle latency.
    cycle(1'b1, 1'b1, 4'd0, 32'hA5A5_0001, '0);
    cycle(1'b1, 1'b1, 4'd8, 32'hDEAD_BEEF, '0);
    check("route latency", 32'(bus.out_valid), 32'h001);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, '0);
    check("route out_valid", 32'(bus.out_valid), 32'h101);
    check("route slot0", bus.out_data[0*W +: W], 32'hA5A5_0001);
    check("route slot8", bus.out_data[8*W +: W], 32'hDEAD_BEEF);

    // Back-pressure on a full slot, other slots unaffected.
    cycle(1'b1, 1'b1, 4'd3, 32'h3333_3333, '0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 4'd3, 32'h9999_9999, '0);
      check("stall in_ready", 32'(bus.in_ready), 32'h0);
      check("stall slot3", bus.out_data[3*W +: W], 32'h3333_3333);
    end
    cycle(1'b1, 1'b1, 4'd4, 32'h4444_4444, '0);
    check("other slot ready", 32'(bus.in_ready), 32'h1);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, '0);
    check("slot4 valid", 32'(bus.out_valid[4]), 32'h1);
    check("slot4 data", bus.out_data[4*W +: W], 32'h4444_4444);

    // Same-cycle consume and reload.
    cycle(1'b1, 1'b1, 4'd3, 32'h0000_1234, 9'h008);
    check("pass ready", 32'(bus.in_ready), 32'h1);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, '0);
    check("pass valid", 32'(bus.out_valid[3]), 32'h1);
    check("pass data", bus.out_data[3*W +: W], 32'h0000_1234);

    // Drain everything.
    cycle(1'b1, 1'b0, 4'd0, 32'h0, '1);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, '0);

    // Out-of-range flags back to back.
    cycle(1'b1, 1'b1, 4'd9, 32'hBAD0_0009, '0);
    check("bad9 ready", 32'(bus.in_ready), 32'h1);
    cycle(1'b1, 1'b1, 4'd15, 32'hBAD0_000F, '0);
    check("bad15 ready", 32'(bus.in_ready), 32'h1);
    check("err first", 32'(bus.err_flag), 32'h1);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, '0);
    check("err second", 32'(bus.err_flag), 32'h1);
    check("drop two", 32'(bus.drop_cnt), 32'h2);
    check("drop no slot", 32'(bus.out_valid), 32'h0);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, '0);
    check("err clear", 32'(bus.err_flag), 32'h0);
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 1'b1, 4'($urandom_range(9, 15)), $urandom, '0);
    end
    cycle(1'b1, 1'b0, 4'd0, 32'h0, '0);
    check("drop saturate", 32'(bus.drop_cnt), 32'd255);

    // Randomized traffic; the source holds a stalled word, with a short
    // reset in the middle.
    sv = 1'b0;
    sf = 4'd0;
    sd = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!blocked) begin
        sv = ($urandom_range(0, 3) != 0);
        sf = 4'($urandom_range(0, 15));
        sd = $urandom;
      end
      cycle((i != 5000) && (i != 5001), sv, sf, sd, N'($urandom));
    end
    cycle(1'b1, 1'b0, 4'd0, 32'h0, '1);
    cycle(1'b1, 1'b0, 4'd0, 32'h0, '0);
    @(negedge clk);
    #4;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
